// File: rtl/nonce_tx_queue_pkg.sv
// Shared definitions for the golden-nonce transmit queue.
package nonce_tx_queue_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [3:0] {
      NTQ_IDLE      = 4'b0001,
      NTQ_SEND      = 4'b0010,
      NTQ_WAIT_BUSY = 4'b0100,
      NTQ_WAIT_DONE = 4'b1000
   } ntq_state_t;

endpackage

// File: rtl/nonce_tx_queue_fifo.sv
// Synchronous nonce FIFO with flush; head word is presented combinationally.
module nonce_tx_queue_fifo
   import nonce_tx_queue_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [NONCE_W-1:0]   din,
   output logic [NONCE_W-1:0]   dout,
   output logic [DEPTH_LOG2:0]  count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [NONCE_W-1:0]    mem_r [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;

   assign dout = mem_r[rd_ptr_r];

   // Storage array; a push and pop at full share a slot, the old head is read before overwrite.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy; callers only push when there is room and only pop when non-empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         count    <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         count    <= {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/nonce_tx_queue.sv
// Queues golden nonces and hands them one at a time to the serial transmit handshake.
module nonce_tx_queue
   import nonce_tx_queue_pkg::*;
#(
   parameter int DEPTH_LOG2   = 3,
   parameter int BUSY_TIMEOUT = 1023,
   parameter int CNT_BITS     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  got_ticket,
   input  logic [NONCE_W-1:0]    golden_nonce,
   input  logic                  flush,
   input  logic                  tx_busy,
   output logic                  tx_ready,
   output logic [NONCE_W-1:0]    word,
   output logic [DEPTH_LOG2:0]   queue_count,
   output logic [CNT_BITS-1:0]   dropped,
   output logic                  pending
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

   ntq_state_t         state_r;
   logic [TW-1:0]      timer_r;
   logic               got_prev_r;
   logic               armed_r;
   logic [NONCE_W-1:0] head_s;
   logic               push_s;
   logic               pop_s;
   logic               push_ok_s;
   logic               drop_s;
   logic               full_s;
   logic               empty_s;
   logic               active_next_s;
   logic [CW-1:0]      cnt_next_s;

   nonce_tx_queue_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok_s),
      .pop   (pop_s),
      .flush (flush),
      .din   (golden_nonce),
      .dout  (head_s),
      .count (queue_count)
   );

   // Capture/pop decisions and next-cycle occupancy used for the registered pending flag.
   always_comb begin
      full_s        = (queue_count == CW'(DEPTH));
      empty_s       = (queue_count == CW'(0));
      push_s        = got_ticket & ~got_prev_r & armed_r;
      pop_s         = (state_r == NTQ_IDLE) & ~empty_s & ~flush;
      push_ok_s     = push_s & ~flush & (~full_s | pop_s);
      drop_s        = push_s & ~flush & full_s & ~pop_s;
      cnt_next_s    = CW'(0);
      active_next_s = 1'b0;
      if (flush) begin
         cnt_next_s = CW'(0);
      end else begin
         cnt_next_s = queue_count + CW'(push_ok_s) - CW'(pop_s);
      end
      case (state_r)
         NTQ_IDLE:      active_next_s = pop_s;
         NTQ_SEND:      active_next_s = 1'b1;
         NTQ_WAIT_BUSY: active_next_s = 1'b1;
         NTQ_WAIT_DONE: active_next_s = tx_busy;
         default:       active_next_s = 1'b0;
      endcase
   end

   // Edge detect, drop counter and transmit handshake FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= NTQ_IDLE;
         timer_r    <= {TW{1'b0}};
         got_prev_r <= 1'b0;
         // A level already high at reset release must not count as a new find.
         armed_r    <= ~got_ticket;
         tx_ready   <= 1'b0;
         word       <= {NONCE_W{1'b0}};
         dropped    <= {CNT_BITS{1'b0}};
         pending    <= 1'b0;
      end else begin
         got_prev_r <= got_ticket;
         armed_r    <= armed_r | ~got_ticket;
         pending    <= (cnt_next_s != CW'(0)) | active_next_s;
         tx_ready   <= 1'b0;
         if (drop_s && (dropped != {CNT_BITS{1'b1}})) begin
            dropped <= dropped + CNT_BITS'(1);
         end
         case (state_r)
            NTQ_IDLE: begin
               if (pop_s) begin
                  word    <= head_s;
                  state_r <= NTQ_SEND;
               end
            end
            NTQ_SEND: begin
               tx_ready <= 1'b1;
               timer_r  <= {TW{1'b0}};
               state_r  <= NTQ_WAIT_BUSY;
            end
            NTQ_WAIT_BUSY: begin
               if (tx_busy) begin
                  state_r <= NTQ_WAIT_DONE;
               end else if (timer_r == TW'(BUSY_TIMEOUT)) begin
                  state_r <= NTQ_SEND;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            NTQ_WAIT_DONE: begin
               if (!tx_busy) begin
                  state_r <= NTQ_IDLE;
               end
            end
            default: state_r <= NTQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Self-checking bench: fixed vector table, directed corner sequences and a randomized run against a queue model.
module tb_nonce_tx_queue;

   localparam int DEPTH = 8;
   localparam int BT    = 1023;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        got_ticket;
   logic [31:0] golden_nonce;
   logic        flush;
   logic        tx_busy;
   logic        tx_ready;
   logic [31:0] word;
   logic [3:0]  queue_count;
   logic [7:0]  dropped;
   logic        pending;

   always #5 clk = ~clk;

   nonce_tx_queue #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(BT), .CNT_BITS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .got_ticket   (got_ticket),
      .golden_nonce (golden_nonce),
      .flush        (flush),
      .tx_busy      (tx_busy),
      .tx_ready     (tx_ready),
      .word         (word),
      .queue_count  (queue_count),
      .dropped      (dropped),
      .pending      (pending)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: an ordered list of waiting nonces plus a description of the word on the wire.
   logic [31:0] mq[$];
   logic [31:0] m_word;
   int          m_drop;
   int          m_wt;
   bit          m_prev, m_armed, m_infl, m_issue, m_seen, m_rdy;

   bit          resp_en;
   int          resp_len;
   int          busy_left;
   logic [31:0] sent[$];
   int          rdy_cyc[$];

   typedef struct {
      logic        gt;
      logic [31:0] nonce;
      logic        busy;
      logic        e_rdy;
      logic [3:0]  e_cnt;
      logic        e_pend;
      logic [31:0] e_word;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit rise, pop;
      if (!rst_n) begin
         mq.delete();
         m_word = 32'h0; m_drop = 0; m_wt = 0;
         m_prev = 1'b0; m_armed = !got_ticket;
         m_infl = 1'b0; m_issue = 1'b0; m_seen = 1'b0; m_rdy = 1'b0;
      end else begin
         rise  = got_ticket && !m_prev && m_armed;
         pop   = !m_infl && (mq.size() != 0) && !flush;
         m_rdy = 1'b0;
         if (m_infl) begin
            if (m_issue) begin
               m_rdy = 1'b1; m_issue = 1'b0; m_wt = 0; m_seen = 1'b0;
            end else if (!m_seen) begin
               if (tx_busy) m_seen = 1'b1;
               else if (m_wt == BT) m_issue = 1'b1;
               else m_wt++;
            end else if (!tx_busy) begin
               m_infl = 1'b0;
            end
         end
         if (pop) begin
            m_word = mq.pop_front();
            m_infl = 1'b1; m_issue = 1'b1;
         end
         if (flush) mq.delete();
         else if (rise) begin
            if (mq.size() < DEPTH) mq.push_back(golden_nonce);
            else if (m_drop < 255) m_drop++;
         end
         m_prev  = got_ticket;
         m_armed = m_armed || !got_ticket;
      end
   endtask

   task automatic check_model();
      chk("m_tx_ready", {31'b0, tx_ready}, {31'b0, m_rdy});
      chk("m_word", word, m_word);
      chk("m_queue_count", {28'b0, queue_count}, 32'(mq.size()));
      chk("m_dropped", {24'b0, dropped}, 32'(m_drop));
      chk("m_pending", {31'b0, pending}, {31'b0, (m_infl || mq.size() != 0)});
   endtask

   task automatic tick();
      if (resp_en) begin
         tx_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
      cyc++;
      if (tx_ready === 1'b1) begin
         sent.push_back(word);
         rdy_cyc.push_back(cyc);
         if (resp_en) busy_left = resp_len;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; got_ticket = 1'b0; golden_nonce = 32'h0; flush = 1'b0; tx_busy = 1'b0;
      resp_en = 1'b0; busy_left = 0;
      tick(); tick();
      rst_n = 1'b1;
      sent.delete(); rdy_cyc.delete();
   endtask

   task automatic pulse(input logic [31:0] n);
      got_ticket = 1'b1; golden_nonce = n; tick();
      got_ticket = 1'b0; golden_nonce = 32'h0; tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd1, 1'b1, 32'h0};
      tbl[2] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 32'h0,        1'b0, 1'b1, 4'd0, 1'b1, 32'hDEADBEEF};
      for (int i = 4; i < 14; i++) tbl[i] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF};
      tbl[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 32'hDEADBEEF};
      tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 32'hDEADBEEF};

      // Reset values and single nonce from the table.
      do_reset();
      chk("reset_tx_ready", {31'b0, tx_ready}, 32'd0);
      chk("reset_pending", {31'b0, pending}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         got_ticket = tbl[i].gt; golden_nonce = tbl[i].nonce; tx_busy = tbl[i].busy;
         tick();
         chk("tbl_tx_ready", {31'b0, tx_ready}, {31'b0, tbl[i].e_rdy});
         chk("tbl_count", {28'b0, queue_count}, {28'b0, tbl[i].e_cnt});
         chk("tbl_pending", {31'b0, pending}, {31'b0, tbl[i].e_pend});
         chk("tbl_word", word, tbl[i].e_word);
      end

      // Burst of five with a slow serial core.
      do_reset();
      resp_en = 1'b1; resp_len = 100;
      for (int i = 1; i <= 5; i++) pulse(32'(i));
      for (int t = 0; t < 1000 && (sent.size() < 5 || pending); t++) tick();
      chk("burst_sent", 32'(sent.size()), 32'd5);
      for (int i = 0; i < 5 && i < sent.size(); i++) chk("burst_order", sent[i], 32'(i + 1));
      chk("burst_dropped", {24'b0, dropped}, 32'd0);

      // Overflow with the serial core stuck busy, then push on a pop at full.
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 10; i++) pulse(32'(100 + i));
      chk("ovf_count", {28'b0, queue_count}, 32'd8);
      chk("ovf_dropped", {24'b0, dropped}, 32'd1);
      chk("ovf_word", word, 32'd100);
      tx_busy = 1'b0; tick();
      got_ticket = 1'b1; golden_nonce = 32'd200; tick();
      chk("ovf_popfull_count", {28'b0, queue_count}, 32'd8);
      chk("ovf_popfull_dropped", {24'b0, dropped}, 32'd1);
      chk("ovf_popfull_word", word, 32'd101);
      got_ticket = 1'b0; tick();

      // Flush while the in-flight word is still being sent.
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) pulse(32'(300 + i));
      chk("flush_pre_count", {28'b0, queue_count}, 32'd4);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_count", {28'b0, queue_count}, 32'd0);
      chk("flush_pending", {31'b0, pending}, 32'd1);
      rdy_cyc.delete();
      tx_busy = 1'b0;
      for (int t = 0; t < 20; t++) tick();
      chk("flush_no_ready", 32'(rdy_cyc.size()), 32'd0);
      chk("flush_idle", {31'b0, pending}, 32'd0);
      chk("flush_dropped", {24'b0, dropped}, 32'd0);

      // Busy never rises: re-issue after the timeout, then finish normally.
      do_reset();
      pulse(32'hCAFE0001);
      for (int t = 0; t < 2200; t++) tick();
      chk("to_pulses", 32'(rdy_cyc.size()), 32'd3);
      if (rdy_cyc.size() >= 3) begin
         chk("to_gap1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'(BT + 2));
         chk("to_gap2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'(BT + 2));
      end
      for (int i = 0; i < sent.size(); i++) chk("to_word", sent[i], 32'hCAFE0001);
      tx_busy = 1'b1; tick(); tick(); tick();
      tx_busy = 1'b0; tick(); tick();
      chk("to_done_pending", {31'b0, pending}, 32'd0);

      // Reset in the middle of a send with entries queued.
      do_reset();
      for (int i = 0; i < 4; i++) pulse(32'(500 + i));
      chk("rst_pre_count", {28'b0, queue_count}, 32'd3);
      rst_n = 1'b0; got_ticket = 1'b1; tick();
      chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
      chk("rst_word", word, 32'd0);
      chk("rst_count", {28'b0, queue_count}, 32'd0);
      chk("rst_dropped", {24'b0, dropped}, 32'd0);
      chk("rst_pending", {31'b0, pending}, 32'd0);
      rst_n = 1'b1; golden_nonce = 32'd777;
      tick(); tick(); tick();
      chk("rst_held_no_capture", {28'b0, queue_count}, 32'd0);
      got_ticket = 1'b0; tick();
      got_ticket = 1'b1; tick();
      chk("rst_rearm_capture", {28'b0, queue_count}, 32'd1);
      got_ticket = 1'b0; tick();

      // Randomized traffic against the model.
      do_reset();
      resp_en = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         got_ticket   = 1'($urandom % 2);
         golden_nonce = $urandom;
         flush        = (($urandom % 50) == 0);
         resp_len     = $urandom_range(1, 30);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
